// File: rtl/sc_window_counter.sv
// rtl/sc_window_counter.sv - windowed popcount accumulator for parallel stochastic bitstreams
module sc_window_counter #(
  parameter int NUM_BITS   = 8,
  parameter int WINDOW_LEN = 256,
  parameter int CONTINUOUS = 0,
  localparam int CNT_W     = $clog2(NUM_BITS * WINDOW_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] data_in,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  input  logic                count_ready,
  output logic                busy
);

  localparam int BEAT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]    pop;
  logic [CNT_W-1:0]    sum;

  // Flat adder chain; synthesis rebalances it into a tree for wide slices.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      pop = pop + CNT_W'(data_in[i]);
    end
  end

  assign sum = acc_q + pop;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          beats_d = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (beats_q == LAST_BEAT) begin
            count_d = sum;
            state_d = DONE;
            acc_d   = '0;
            beats_d = '0;
          end else begin
            acc_d   = sum;
            beats_d = beats_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (count_ready) begin
          state_d = (CONTINUOUS != 0) ? ACCUM : IDLE;
          acc_d   = '0;
          beats_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over everything but leaves the last published count in place.
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      beats_d = '0;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      beats_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      count_q <= count_d;
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign count_valid = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign count       = count_q;

endmodule

// File: tb/tb_sc_window_counter.sv
// tb/tb_sc_window_counter.sv - directed bench for sc_window_counter (one-shot and continuous instances)
module tb_sc_window_counter;

  logic       clk;
  logic       rst;

  logic       a_start, a_abort, a_in_valid, a_in_ready, a_count_valid, a_count_ready, a_busy;
  logic [7:0] a_data_in;
  logic [5:0] a_count;

  logic       b_start, b_abort, b_in_valid, b_in_ready, b_count_valid, b_count_ready, b_busy;
  logic [7:0] b_data_in;
  logic [5:0] b_count;

  int compared = 0;
  int mismatched = 0;

  sc_window_counter #(.NUM_BITS(8), .WINDOW_LEN(4), .CONTINUOUS(0)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
    .count(a_count), .count_valid(a_count_valid), .count_ready(a_count_ready),
    .busy(a_busy)
  );

  sc_window_counter #(.NUM_BITS(8), .WINDOW_LEN(4), .CONTINUOUS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .count(b_count), .count_valid(b_count_valid), .count_ready(b_count_ready),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks in_ready, count_valid, busy and count of instance A in one call.
  task automatic check_a(input string tag, input logic rdy, input logic vld,
                         input logic bsy, input logic [5:0] cnt);
    check({tag, ".in_ready"}, 32'(a_in_ready), 32'(rdy));
    check({tag, ".count_valid"}, 32'(a_count_valid), 32'(vld));
    check({tag, ".busy"}, 32'(a_busy), 32'(bsy));
    check({tag, ".count"}, 32'(a_count), 32'(cnt));
  endtask

  task automatic beat_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_data_in  = d;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_data_in  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_in_valid = 0; a_count_ready = 0; a_data_in = '0;
    b_start = 0; b_abort = 0; b_in_valid = 0; b_count_ready = 0; b_data_in = '0;
    tick();
    check_a("reset", 0, 0, 0, 0);
    check("reset.b_busy", 32'(b_busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1. full scale
    a_start = 1; tick(); a_start = 0;
    check_a("t1.armed", 1, 0, 1, 0);
    beat_a(8'hFF); beat_a(8'hFF); beat_a(8'hFF);
    check_a("t1.beat3", 1, 0, 1, 0);
    beat_a(8'hFF);
    check_a("t1.done", 0, 1, 1, 32);
    a_start = 1; tick(); a_start = 0;
    check_a("t1.start_in_done", 0, 1, 1, 32);
    a_count_ready = 1; tick(); a_count_ready = 0;
    check_a("t1.idle", 0, 0, 0, 32);

    // 2. gapped input; data toggles while in_valid is low
    a_start = 1; tick(); a_start = 0;
    beat_a(8'h01);
    a_data_in = 8'hFF; tick();
    check_a("t2.gap1", 1, 0, 1, 32);
    beat_a(8'h03);
    a_data_in = 8'hFF; tick(); tick();
    beat_a(8'h07);
    a_data_in = 8'hFF; tick(); tick(); tick();
    check_a("t2.gap3", 1, 0, 1, 32);
    beat_a(8'h0F);
    check_a("t2.done", 0, 1, 1, 10);

    // 3. backpressure, offered data must be ignored
    a_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      a_data_in = (i % 2 == 0) ? 8'hFF : 8'h55;
      tick();
      check_a("t3.hold", 0, 1, 1, 10);
    end
    a_in_valid = 0;
    a_count_ready = 1; tick(); a_count_ready = 0;
    check_a("t3.released", 0, 0, 0, 10);

    // 4. abort mid-window, start+abort same cycle, then clean window
    a_start = 1; tick(); a_start = 0;
    beat_a(8'hFF); beat_a(8'hFF);
    a_abort = 1; tick(); a_abort = 0;
    check_a("t4.aborted", 0, 0, 0, 10);
    a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0;
    check_a("t4.start_abort", 0, 0, 0, 10);
    a_start = 1; tick(); a_start = 0;
    beat_a(8'h11); beat_a(8'h11); beat_a(8'h11); beat_a(8'h11);
    check_a("t4.done", 0, 1, 1, 8);
    // abort together with handshake still leaves IDLE and count intact
    a_abort = 1; a_count_ready = 1; tick(); a_abort = 0; a_count_ready = 0;
    check_a("t4.abort_hs", 0, 0, 0, 8);

    // 5. continuous mode
    b_start = 1; tick(); b_start = 0;
    beat_b(8'hAA); beat_b(8'hAA); beat_b(8'hAA); beat_b(8'hAA);
    check("t5.count1", 32'(b_count), 16);
    check("t5.valid1", 32'(b_count_valid), 1);
    b_count_ready = 1; tick(); b_count_ready = 0;
    check("t5.rearm.in_ready", 32'(b_in_ready), 1);
    check("t5.rearm.valid", 32'(b_count_valid), 0);
    check("t5.rearm.busy", 32'(b_busy), 1);
    beat_b(8'h00); beat_b(8'h00); beat_b(8'h00);
    check("t5.mid.valid", 32'(b_count_valid), 0);
    beat_b(8'h00);
    check("t5.count2", 32'(b_count), 0);
    check("t5.valid2", 32'(b_count_valid), 1);

    // 6. async reset mid-ACCUM on instance A
    a_start = 1; tick(); a_start = 0;
    beat_a(8'hFF); beat_a(8'h0F);
    #3;
    rst = 1; a_start = 1; a_in_valid = 1; a_data_in = 8'hFF;
    #1;
    check_a("t6.async", 0, 0, 0, 0);
    check("t6.b_busy", 32'(b_busy), 0);
    tick(); tick();
    check_a("t6.held", 0, 0, 0, 0);
    #3;
    rst = 0; a_start = 0; a_in_valid = 0;
    tick();
    check_a("t6.after", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
